// File: rtl/dadda_reduce_pipe.sv
// Pipelined partial-product generator and Dadda reduction tree (unsigned WIDTH x WIDTH).
// Each transaction leaves as two 2*WIDTH-bit rows plus its czero tag for the final adder.
module dadda_reduce_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 czero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   row_a,
  output logic [2*WIDTH-1:0]   row_b,
  output logic                 out_czero
);

  if (WIDTH != 4 && WIDTH != 8) begin : g_bad_width
    $error("dadda_reduce_pipe: WIDTH must be 4 or 8");
  end

  localparam int W      = int'(WIDTH);
  localparam int NCOL   = 2 * W;
  localparam int MAXH   = W;
  localparam int NSTAGE = (W == 8) ? 4 : 2;
  localparam int NSLOT  = NSTAGE + 1;

  typedef logic [NCOL-1:0][MAXH-1:0] cols_t;

  // Target height of reduction stage s (1-based), walking the sequence 6,4,3,2 downwards.
  function automatic int stage_d(input int s);
    case (NSTAGE - s)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      default: return 6;
    endcase
  endfunction

  // Height of column c after s reduction stages; s = 0 is the raw partial-product array.
  function automatic int col_h(input int s, input int c);
    int h [NCOL];
    int cin, n, d;
    for (int k = 0; k < NCOL; k++) h[k] = (k < W) ? k + 1 : NCOL - 1 - k;
    for (int st = 1; st <= s; st++) begin
      d   = stage_d(st);
      cin = 0;
      for (int k = 0; k < NCOL; k++) begin
        n = h[k] + cin;
        if (n > d) begin
          cin  = (n - d + 1) / 2;
          h[k] = d;
        end else begin
          cin  = 0;
          h[k] = n;
        end
      end
    end
    return h[c];
  endfunction

  function automatic cols_t pp_gen(input logic [W-1:0] a, input logic [W-1:0] b);
    cols_t y;
    int    cnt [NCOL];
    y = '0;
    for (int k = 0; k < NCOL; k++) cnt[k] = 0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        y[i+j][cnt[i+j]] = a[i] & b[j];
        cnt[i+j]++;
      end
    end
    return y;
  endfunction

  // One Dadda stage: adders consume a column's own bits first, so carries arriving from
  // the column below within this stage pass straight through (one FA level per stage).
  function automatic cols_t reduce(input cols_t x, input int s);
    cols_t              y;
    logic [2*MAXH-1:0]  lst;
    logic [MAXH-1:0]    cp, cc;
    int                 ncp, ncc, h, d, k, n, pos;
    y   = '0;
    cp  = '0;
    ncp = 0;
    d   = stage_d(s);
    for (int c = 0; c < NCOL; c++) begin
      h   = col_h(s - 1, c);
      lst = '0;
      for (int i = 0; i < MAXH; i++) if (i < h) lst[i] = x[c][i];
      for (int i = 0; i < MAXH; i++) if (i < ncp) lst[h+i] = cp[i];
      n   = h + ncp;
      k   = 0;
      pos = 0;
      ncc = 0;
      cc  = '0;
      for (int t = 0; t < MAXH; t++) begin
        if (n > d) begin
          if (n - d >= 2) begin
            y[c][pos] = lst[k] ^ lst[k+1] ^ lst[k+2];
            cc[ncc]   = (lst[k] & lst[k+1]) | (lst[k+2] & (lst[k] ^ lst[k+1]));
            k += 3;
            n -= 2;
          end else begin
            y[c][pos] = lst[k] ^ lst[k+1];
            cc[ncc]   = lst[k] & lst[k+1];
            k += 2;
            n -= 1;
          end
          pos++;
          ncc++;
        end
      end
      for (int i = 0; i < 2 * MAXH; i++) begin
        if (i >= k && i < h + ncp) begin
          y[c][pos] = lst[i];
          pos++;
        end
      end
      cp  = cc;
      ncp = ncc;
    end
    return y;
  endfunction

  cols_t             col_q [NSLOT];
  cols_t             col_d [NSLOT];
  logic [NSLOT-1:0]  valid_q, cz_q, load, up_valid, up_cz;

  assign up_valid = {valid_q[NSLOT-2:0], in_valid};
  assign up_cz    = {cz_q[NSLOT-2:0], czero};

  always_comb begin
    col_d[0] = pp_gen(in1, in2);
    for (int k = 1; k < NSLOT; k++) col_d[k] = reduce(col_q[k-1], k);
  end

  // Bubble-collapsing: a slot advances when empty or when the slot after it advances.
  always_comb begin
    logic chain;
    load  = '0;
    chain = out_ready | ~valid_q[NSLOT-1];
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (k < NSLOT - 1) chain = ~valid_q[k] | chain;
      load[k] = chain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cz_q    <= '0;
      for (int k = 0; k < NSLOT; k++) col_q[k] <= '0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (load[k]) valid_q[k] <= up_valid[k];
        if (load[k] && up_valid[k]) begin
          col_q[k] <= col_d[k];
          cz_q[k]  <= up_cz[k];
        end
      end
    end
  end

  always_comb begin
    row_a = '0;
    row_b = '0;
    for (int c = 0; c < NCOL; c++) begin
      row_a[c] = col_q[NSLOT-1][c][0] & ~rst;
      row_b[c] = col_q[NSLOT-1][c][1] & ~rst;
    end
  end

  assign out_valid = valid_q[NSLOT-1] & ~rst;
  assign out_czero = cz_q[NSLOT-1] & ~rst;
  assign in_ready  = load[0] & ~rst;

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Scoreboard bench: WIDTH=8 instance for latency/flow/reset, WIDTH=4 instance exhaustive.
module tb_dadda_reduce_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv8 = 0, ir8, cz8 = 0, ov8, or8 = 1, ocz8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] ra8, rb8;
  logic        iv4 = 0, ir4, cz4 = 0, ov4, or4 = 1, ocz4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  ra4, rb4;

  dadda_reduce_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8), .czero(cz8),
    .out_valid(ov8), .out_ready(or8), .row_a(ra8), .row_b(rb8), .out_czero(ocz8)
  );

  dadda_reduce_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in1(a4), .in2(b4), .czero(cz4),
    .out_valid(ov4), .out_ready(or4), .row_a(ra4), .row_b(rb4), .out_czero(ocz4)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cz;
    int          t;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0, failures = 0, cyc = 0, acc8 = 0, del8 = 0, del4 = 0;
  bit   chk_lat8 = 0, bub_done = 0;

  // Directed vectors with hand-computed products.
  logic [7:0]  da [8] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h0F, 8'hAA, 8'h12, 8'h80};
  logic [7:0]  db [8] = '{8'h00, 8'h01, 8'h02, 8'h01, 8'hF0, 8'h55, 8'h34, 8'h80};
  logic [15:0] dp [8] = '{16'h0000, 16'h0001, 16'h0100, 16'h00FF,
                          16'h0E10, 16'h3872, 16'h03A8, 16'h4000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Output monitor, WIDTH=8: pops on handshake, checks hold during stalls.
  initial begin
    exp_t        e;
    logic        stall;
    logic [31:0] prow;
    logic        pcz;
    stall = 0;
    prow  = '0;
    pcz   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid8", ov8, 1);
          chk("hold_rows8", {ra8, rb8}, prow);
          chk("hold_cz8", ocz8, pcz);
        end
        stall = ov8 && !or8;
        prow  = {ra8, rb8};
        pcz   = ocz8;
        if (ov8 && or8) begin
          chk("out8_expected", q8.size() != 0, 1);
          if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("sum8", 16'(ra8 + rb8), e.sum);
            chk("cz8", ocz8, e.cz);
            if (chk_lat8) chk("lat8", cyc - e.t, 5);
            del8++;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov4 && or4) begin
        chk("out4_expected", q4.size() != 0, 1);
        if (q4.size() != 0) begin
          e = q4.pop_front();
          chk("sum4", 8'(ra4 + rb4), e.sum);
          chk("cz4", ocz4, e.cz);
          chk("lat4", cyc - e.t, 3);
          del4++;
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 after acceptance, in_valid left high.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cz,
                       input logic [15:0] req, output int waits);
    bit done;
    iv8 = 1; a8 = a; b8 = b; cz8 = cz;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (ir8) begin
        done = 1;
        q8.push_back('{sum: req, cz: cz, t: cyc});
        acc8++;
      end else begin
        waits++;
        if (waits > 200) begin
          chk("accept8_timeout", ir8, 1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cz,
                       input logic [7:0] req);
    int  waits;
    bit  done;
    iv4 = 1; a4 = a; b4 = b; cz4 = cz;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (ir4) begin
        done = 1;
        q4.push_back('{sum: 16'(req), cz: cz, t: cyc});
      end else begin
        waits++;
        if (waits > 200) begin
          chk("accept4_timeout", ir4, 1);
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", q8.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", q4.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          w, n_acc, dsave;
    logic        last_ir;
    logic [7:0]  ra, rb;

    @(negedge clk);
    chk("rst_in_ready", ir8, 0);
    chk("rst_out_valid", ov8, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", ir8, 1);
    chk("post_rst_out_valid", ov8, 0);
    chk("post_rst_rows", {ra8, rb8}, 0);
    chk("post_rst_cz", ocz8, 0);
    @(posedge clk); #1;

    // Single op, then directed table, then streaming; latency checked throughout.
    chk_lat8 = 1;
    send8(8'hFF, 8'hFF, 1'b1, 16'hFE01, w);
    iv8 = 0;
    drain8();
    for (int i = 0; i < 8; i++) send8(da[i], db[i], 1'(i), dp[i], w);
    iv8 = 0;
    drain8();
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send8(ra, rb, 1'($urandom), ra * rb, w);
      chk("stream_in_ready", w, 0);
    end
    iv8 = 0;
    drain8();
    chk_lat8 = 0;

    // Backpressure: ten stalled cycles with in_valid held high.
    or8   = 0;
    n_acc = 0;
    ra    = 8'($urandom);
    rb    = 8'($urandom);
    last_ir = 1;
    for (int i = 0; i < 10; i++) begin
      iv8 = 1; a8 = ra; b8 = rb; cz8 = 1'(i);
      @(negedge clk);
      last_ir = ir8;
      if (ir8) begin
        q8.push_back('{sum: ra * rb, cz: 1'(i), t: cyc});
        acc8++;
        n_acc++;
        ra = 8'($urandom);
        rb = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("bp_accepted", n_acc, 5);
    chk("bp_in_ready_low", last_ir, 0);
    iv8 = 0;
    or8 = 1;
    drain8();

    // Bubbles with random downstream readiness.
    bub_done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          send8(ra, rb, 1'($urandom), ra * rb, w);
          iv8 = 0;
          @(posedge clk); #1;
        end
        bub_done = 1;
      end
      begin
        while (!bub_done) begin
          or8 = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        or8 = 1;
      end
    join
    drain8();
    chk("acc_vs_del", del8, acc8);

    // Reset with three transactions in flight.
    send8(8'h11, 8'h22, 1'b1, 16'h0242, w);
    send8(8'h33, 8'h44, 1'b0, 16'h0D8C, w);
    send8(8'h55, 8'h66, 1'b1, 16'h21DE, w);
    iv8 = 0;
    rst = 1;
    q8.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_in_ready", ir8, 1);
    dsave = del8;
    repeat (12) @(negedge clk);
    chk("midrst_no_ghost", del8, dsave);
    @(posedge clk); #1;

    // WIDTH=4 exhaustive with alternating czero.
    for (int i = 0; i < 256; i++) begin
      send4(4'(i >> 4), 4'(i), 1'(i), 8'((i >> 4) * (i & 15)));
    end
    iv4 = 0;
    drain4();
    chk("w4_count", del4, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
